bsr_meta_tx: RTL and testbench
==============================

// Module: bsr_meta_tx
// PURPOSE
// - Transmit end of the DMA->metadata-decoder link.
// - Takes raw BSR metadata beats from the DMA read stream. Emits them as typed
//   words: 2x BLOCK_HDR, then ROW_PTR (num_rows+1 words), then COL_IDX
//   (ceil(total_blocks/2) words, two 16-bit indices per word).
// - Drives the dma_meta_* inputs of the metadata decoder.
// - Fully honours its dma_meta_ready backpressure.
// PARAMETERS
// - DATA_WIDTH   32  beat/word width (only 32 supported)
// - CNT_W        32  width of the internal word counters
// - ENABLE_PERF  1   1 = perf_words_sent/perf_stall_cycles count; 0 = tied to 0
// PORTS
// - clk                  in   1   single clock
// - rst_n                in   1   asynchronous, active-low reset
// - start                in   1   one-cycle pulse; latch cfg_* and begin a transfer
// - abort                in   1   synchronous cancel of the current transfer
// - cfg_num_rows         in   16  block rows
// - cfg_num_cols         in   16  block cols
// - cfg_total_blocks     in   32  nonzero blocks (nnz)
// - cfg_block_size       in   3   0=4x4, 1=8x8, 2=16x16
// - in_data              in   32  DMA read beat
// - in_valid             in   1   beat valid
// - in_ready             out  1   beat accepted when in_valid & in_ready
// - dma_meta_data        out  32  metadata word
// - dma_meta_valid       out  4   per-byte valid
// - dma_meta_type        out  2   0=ROW_PTR, 1=COL_IDX, 2=BLOCK_HDR
// - dma_meta_wen         out  1   word valid
// - dma_meta_ready       in   1   word accepted when dma_meta_wen & dma_meta_ready
// - busy                 out  1   state != IDLE
// - done                 out  1   one-cycle pulse after the last word is accepted
// - err_start_busy       out  1   sticky; start seen while busy; cleared by next accepted start
// - perf_words_sent      out  32  accepted words, all transfers
// - perf_stall_cycles    out  32  cycles with dma_meta_wen & !dma_meta_ready
// BEHAVIOUR
// - Reset values: in_ready=0, dma_meta_*=0, busy=0, done=0, err=0, perf=0, state=IDLE.
// - Handshake: while dma_meta_wen=1 and ready=0, data/valid/type are held stable.
// - Output is a single register stage.
// - in_ready = (state is ROWPTR or COLIDX) & (!dma_meta_wen | dma_meta_ready).
//   An accepted beat appears on dma_meta_* the next cycle: latency 1, full throughput.
// - States: IDLE -> HDR0 -> HDR1 -> ROWPTR -> COLIDX -> DONE -> IDLE.
// - IDLE: on start, latch cfg_* and go to HDR0. Set rp_left = num_rows+1
//   (17-bit, no wrap) and ci_left = ceil(nnz/2) = (nnz>>1) + nnz[0].
// - HDR0: drive {num_rows, num_cols}, type 2, valid F. Advance on accept.
// - HDR1: drive {cfg_block_size in [31:29], total_blocks[28:0]}, type 2, valid F.
//   Advance on accept.
// - ROWPTR: forward each beat as type 0, valid F; decrement rp_left per accepted beat.
//   Go to COLIDX when rp_left hits 0, or to DONE if ci_left == 0 (nnz = 0).
// - COLIDX: forward beats as type 1. Last word has valid 4'h3 if nnz is odd, else 4'hF.
//   All other words use 4'hF. Go to DONE after ci_left reaches 0 and the last word
//   is accepted.
// - The last word must be accepted (wen & ready) before DONE. No beats are taken
//   once the counter reaches 0.
// - DONE: done=1 for one cycle, dma_meta_wen=0, then IDLE.
// - start while busy: ignored, err_start_busy set.
// - start and abort in the same cycle in IDLE: abort wins.
// - abort in any state: next cycle IDLE, dma_meta_wen=0, in_ready=0, no done pulse.
//   Counters cleared, perf counters kept. A half-sent word is dropped; the receiver
//   sees no handshake for it.
// - Async reset mid-transfer: all outputs go to reset values immediately.
//   No partial word is completed.
// - Perf counters wrap at 2^32 (modulo). They are frozen at 0 when ENABLE_PERF=0.
// TESTING
// - T1: rows=2, cols=4, nnz=3, ready=1, beats A0..A2 and C0,C1 ->
//   7 words typed 2,2,0,0,0,1,1; last valid=4'h3; done 1 cycle after C1 accept.
// - T2: T1 with ready low 3 cycles during HDR1 and random gaps in in_valid ->
//   held words unchanged, same word order, perf_stall_cycles=3.
// - T3: nnz=0, rows=1 -> HDR, HDR, 2 ROW_PTR, then DONE; no COL_IDX words;
//   in_ready drops after the 2nd row beat.
// - T4: start again while busy -> err_start_busy=1, transfer unaffected;
//   next start from IDLE clears it.
// - T5: abort while a word is stalled in ROWPTR -> next cycle wen=0, busy=0,
//   no done pulse; a fresh start then runs a clean T1.
// - T6: rst_n low mid-COLIDX -> all outputs 0 asynchronously; perf counters back to 0.

Source files
------------

// File: rtl/bsr_meta_tx_if.sv
// Bus bundle for bsr_meta_tx: the DMA read-beat stream in and the typed
// metadata word stream out towards the metadata decoder.
interface bsr_meta_tx_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dma_meta_data;
  logic [3:0]  dma_meta_valid;
  logic [1:0]  dma_meta_type;
  logic        dma_meta_wen;
  logic        dma_meta_ready;

  modport master (
    input  in_data,
    input  in_valid,
    input  dma_meta_ready,
    output in_ready,
    output dma_meta_data,
    output dma_meta_valid,
    output dma_meta_type,
    output dma_meta_wen
  );

  modport slave (
    output in_data,
    output in_valid,
    output dma_meta_ready,
    input  in_ready,
    input  dma_meta_data,
    input  dma_meta_valid,
    input  dma_meta_type,
    input  dma_meta_wen
  );
endinterface

// File: rtl/bsr_meta_tx.sv
// Transmit end of the DMA->metadata-decoder link: wraps raw BSR metadata beats
// into typed words (2x BLOCK_HDR, ROW_PTR, COL_IDX) behind one output register.
module bsr_meta_tx #(
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_W       = 32,
  parameter int ENABLE_PERF = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         cfg_num_rows,
  input  logic [15:0]         cfg_num_cols,
  input  logic [31:0]         cfg_total_blocks,
  input  logic [2:0]          cfg_block_size,
  bsr_meta_tx_if.master       bus,
  output logic                busy,
  output logic                done,
  output logic                err_start_busy,
  output logic [31:0]         perf_words_sent,
  output logic [31:0]         perf_stall_cycles
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR0   = 3'd1;
  localparam logic [2:0] ST_HDR1   = 3'd2;
  localparam logic [2:0] ST_ROWPTR = 3'd3;
  localparam logic [2:0] ST_COLIDX = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [1:0] TYPE_ROW_PTR   = 2'd0;
  localparam logic [1:0] TYPE_COL_IDX   = 2'd1;
  localparam logic [1:0] TYPE_BLOCK_HDR = 2'd2;

  logic [2:0]            state_q;
  logic [31:0]           nnz_q;
  logic [2:0]            bsize_q;
  logic [CNT_W-1:0]      rp_left_q;
  logic [CNT_W-1:0]      ci_left_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            valid_q;
  logic [1:0]            type_q;
  logic                  wen_q;
  logic                  err_q;

  logic                  accept;
  logic                  can_load;
  logic                  take;
  logic                  rp_more;
  logic                  ci_more;
  logic [CNT_W-1:0]      rp_init;
  logic [CNT_W-1:0]      ci_init;

  assign accept   = wen_q && bus.dma_meta_ready;
  assign can_load = !wen_q || bus.dma_meta_ready;
  assign rp_more  = (rp_left_q != '0);
  assign ci_more  = (ci_left_q != '0);

  // Beats are only pulled while the output slot frees up this cycle and words remain.
  assign bus.in_ready = can_load &&
                        (((state_q == ST_ROWPTR) && rp_more) ||
                         ((state_q == ST_COLIDX) && ci_more));
  assign take = bus.in_valid && bus.in_ready;

  assign rp_init = CNT_W'(cfg_num_rows) + CNT_W'(1);
  assign ci_init = CNT_W'(cfg_total_blocks >> 1) + CNT_W'(cfg_total_blocks[0]);

  assign bus.dma_meta_data  = data_q;
  assign bus.dma_meta_valid = valid_q;
  assign bus.dma_meta_type  = type_q;
  assign bus.dma_meta_wen   = wen_q;

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign err_start_busy = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      nnz_q     <= '0;
      bsize_q   <= '0;
      rp_left_q <= '0;
      ci_left_q <= '0;
      data_q    <= '0;
      valid_q   <= '0;
      type_q    <= '0;
      wen_q     <= 1'b0;
    end else if (abort) begin
      // Any pending word is dropped without a handshake.
      state_q   <= ST_IDLE;
      rp_left_q <= '0;
      ci_left_q <= '0;
      data_q    <= '0;
      valid_q   <= '0;
      type_q    <= '0;
      wen_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            nnz_q     <= cfg_total_blocks;
            bsize_q   <= cfg_block_size;
            rp_left_q <= rp_init;
            ci_left_q <= ci_init;
            data_q    <= {cfg_num_rows, cfg_num_cols};
            valid_q   <= 4'hF;
            type_q    <= TYPE_BLOCK_HDR;
            wen_q     <= 1'b1;
            state_q   <= ST_HDR0;
          end
        end
        ST_HDR0: begin
          if (accept) begin
            data_q  <= {bsize_q, nnz_q[28:0]};
            state_q <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (accept) begin
            wen_q   <= 1'b0;
            state_q <= ST_ROWPTR;
          end
        end
        ST_ROWPTR: begin
          if (take) begin
            data_q    <= bus.in_data;
            valid_q   <= 4'hF;
            type_q    <= TYPE_ROW_PTR;
            wen_q     <= 1'b1;
            rp_left_q <= rp_left_q - CNT_W'(1);
            if ((rp_left_q == CNT_W'(1)) && ci_more) begin
              state_q <= ST_COLIDX;
            end
          end else begin
            if (accept) begin
              wen_q <= 1'b0;
            end
            // nnz = 0: finish only once the last row pointer has drained.
            if (!rp_more && can_load) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_COLIDX: begin
          if (take) begin
            data_q    <= bus.in_data;
            valid_q   <= ((ci_left_q == CNT_W'(1)) && nnz_q[0]) ? 4'h3 : 4'hF;
            type_q    <= TYPE_COL_IDX;
            wen_q     <= 1'b1;
            ci_left_q <= ci_left_q - CNT_W'(1);
          end else begin
            if (accept) begin
              wen_q <= 1'b0;
            end
            if (!ci_more && can_load) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          wen_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          wen_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky until a start is actually taken from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (start && busy) begin
      err_q <= 1'b1;
    end else if (start && !abort && (state_q == ST_IDLE)) begin
      err_q <= 1'b0;
    end
  end

  generate
    if (ENABLE_PERF != 0) begin : g_perf
      logic [31:0] words_q;
      logic [31:0] stalls_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          words_q  <= '0;
          stalls_q <= '0;
        end else begin
          words_q  <= words_q + 32'(accept);
          stalls_q <= stalls_q + 32'(wen_q && !bus.dma_meta_ready);
        end
      end

      assign perf_words_sent   = words_q;
      assign perf_stall_cycles = stalls_q;
    end else begin : g_no_perf
      assign perf_words_sent   = '0;
      assign perf_stall_cycles = '0;
    end
  endgenerate

endmodule

// File: tb/tb_bsr_meta_tx.sv
// Directed bench for bsr_meta_tx: table of whole transfers checked against a
// word scoreboard, plus hand sequences for abort and mid-transfer reset.
module tb_bsr_meta_tx;

  typedef struct {
    logic [15:0] rows;
    logic [15:0] cols;
    logic [31:0] nnz;
    logic [2:0]  bsize;
    logic [31:0] exp_hdr0;
    logic [31:0] exp_hdr1;
    int          exp_words;
    logic [3:0]  exp_last_valid;
    bit          gaps;
    bit          stall;
    bit          busy_start;
    int          exp_stalls;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  v;
    logic [1:0]  t;
  } word_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_num_rows;
  logic [15:0] cfg_num_cols;
  logic [31:0] cfg_total_blocks;
  logic [2:0]  cfg_block_size;
  logic        busy;
  logic        done;
  logic        err_start_busy;
  logic [31:0] perf_words_sent;
  logic [31:0] perf_stall_cycles;

  bsr_meta_tx_if bus();

  bsr_meta_tx dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .abort             (abort),
    .cfg_num_rows      (cfg_num_rows),
    .cfg_num_cols      (cfg_num_cols),
    .cfg_total_blocks  (cfg_total_blocks),
    .cfg_block_size    (cfg_block_size),
    .bus               (bus),
    .busy              (busy),
    .done              (done),
    .err_start_busy    (err_start_busy),
    .perf_words_sent   (perf_words_sent),
    .perf_stall_cycles (perf_stall_cycles)
  );

  int          n_checks;
  int          n_errors;
  word_t       got[$];
  word_t       exp_q[$];
  logic [31:0] beats[$];
  int          beat_idx;
  int          n_beats;
  int          exp_beats;
  bit          drive_en;
  bit          gaps;
  bit          in_fire;
  int          cyc;
  int          done_cnt;
  int          done_cyc;
  int          last_acc_cyc;
  bit          prev_stall;
  word_t       prev_word;
  vec_t        tbl[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Negedge monitor: records handshakes that the next posedge will complete.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      in_fire    = 1'b0;
    end else begin
      cyc++;
      if (prev_stall && bus.dma_meta_wen)
        checkOutput("held_word", {bus.dma_meta_data, bus.dma_meta_valid, bus.dma_meta_type}, prev_word);
      prev_stall = bus.dma_meta_wen && !bus.dma_meta_ready;
      prev_word  = {bus.dma_meta_data, bus.dma_meta_valid, bus.dma_meta_type};
      in_fire    = bus.in_valid && bus.in_ready;
      if (bus.dma_meta_wen && bus.dma_meta_ready) begin
        got.push_back({bus.dma_meta_data, bus.dma_meta_valid, bus.dma_meta_type});
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Beat source with optional random gaps in in_valid.
  always @(posedge clk) begin
    #1;
    if (in_fire) beat_idx++;
    in_fire = 1'b0;
    if (drive_en && beat_idx < n_beats && (!gaps || $urandom_range(0, 2) != 0)) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beats[beat_idx];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
    end
  end

  task automatic prepTransfer(input vec_t r);
    int nrp;
    int nci;
    nrp = int'(r.rows) + 1;
    nci = int'(r.nnz / 2 + r.nnz % 2);
    @(negedge clk);
    beats.delete();
    exp_q.delete();
    got.delete();
    exp_q.push_back({r.exp_hdr0, 4'hF, 2'd2});
    exp_q.push_back({r.exp_hdr1, 4'hF, 2'd2});
    for (int i = 0; i < nrp; i++) begin
      beats.push_back(32'hA000_0000 + i);
      exp_q.push_back({32'hA000_0000 + i, 4'hF, 2'd0});
    end
    for (int i = 0; i < nci; i++) begin
      beats.push_back(32'hC000_0000 + i);
      exp_q.push_back({32'hC000_0000 + i, (i == nci - 1) ? r.exp_last_valid : 4'hF, 2'd1});
    end
    beats.push_back(32'hEEEE_0000);
    beats.push_back(32'hEEEE_0001);
    exp_beats        = nrp + nci;
    n_beats          = beats.size();
    beat_idx         = 0;
    gaps             = r.gaps;
    drive_en         = 1'b1;
    cfg_num_rows     = r.rows;
    cfg_num_cols     = r.cols;
    cfg_total_blocks = r.nnz;
    cfg_block_size   = r.bsize;
  endtask

  task automatic applyStimulus(input vec_t r, input string tag);
    logic [31:0] w0;
    logic [31:0] s0;
    int          d0;
    bit          seen;
    prepTransfer(r);
    w0 = perf_words_sent;
    s0 = perf_stall_cycles;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    bus.dma_meta_ready = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 300 && !seen; k++) begin
      @(posedge clk); #1;
      start = r.busy_start && (k == 4);
      bus.dma_meta_ready = !(r.stall && k >= 2 && k <= 4);
      seen = (done_cnt != d0);
    end
    start = 1'b0;
    bus.dma_meta_ready = 1'b1;
    checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    drive_en = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    checkOutput({tag, "_done_latency"}, 64'(done_cyc), 64'(last_acc_cyc + 1));
    checkOutput({tag, "_word_count"}, 64'(got.size()), 64'(r.exp_words));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("%s_word%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    checkOutput({tag, "_beats_taken"}, 64'(beat_idx), 64'(exp_beats));
    checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
    checkOutput({tag, "_err"}, 64'(err_start_busy), 64'(r.busy_start));
    checkOutput({tag, "_perf_words"}, 64'(perf_words_sent - w0), 64'(r.exp_words));
    checkOutput({tag, "_perf_stalls"}, 64'(perf_stall_cycles - s0), 64'(r.exp_stalls));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] w0;
    logic [31:0] s0;
    int          d0;
    bit          seen;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_num_rows = '0;
    cfg_num_cols = '0;
    cfg_total_blocks = '0;
    cfg_block_size = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.dma_meta_ready = 1'b1;
    drive_en = 1'b0;
    gaps = 1'b0;
    n_beats = 0;
    beat_idx = 0;
    cyc = 0;
    done_cnt = 0;
    done_cyc = 0;
    last_acc_cyc = 0;

    //            rows   cols   nnz    bs    hdr0          hdr1          words last  gap stl bst stalls
    tbl[0] = '{16'd2, 16'd4, 32'd3, 3'd1, 32'h0002_0004, 32'h2000_0003, 7, 4'h3, 0, 0, 0, 0};
    tbl[1] = '{16'd2, 16'd4, 32'd3, 3'd1, 32'h0002_0004, 32'h2000_0003, 7, 4'h3, 1, 1, 0, 3};
    tbl[2] = '{16'd1, 16'd1, 32'd0, 3'd0, 32'h0001_0001, 32'h0000_0000, 4, 4'hF, 0, 0, 0, 0};
    tbl[3] = '{16'd3, 16'd5, 32'd4, 3'd2, 32'h0003_0005, 32'h4000_0004, 8, 4'hF, 1, 0, 1, 0};
    tbl[4] = '{16'd0, 16'd7, 32'd1, 3'd0, 32'h0000_0007, 32'h0000_0001, 4, 4'h3, 0, 0, 0, 0};
    tbl[5] = '{16'd2, 16'd3, 32'd5, 3'd2, 32'h0002_0003, 32'h4000_0005, 8, 4'h3, 1, 0, 0, 0};

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("rst_wen", 64'(bus.dma_meta_wen), 64'd0);
    checkOutput("rst_data", 64'(bus.dma_meta_data), 64'd0);
    checkOutput("rst_valid", 64'(bus.dma_meta_valid), 64'd0);
    checkOutput("rst_type", 64'(bus.dma_meta_type), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err_start_busy), 64'd0);
    checkOutput("rst_perf_words", 64'(perf_words_sent), 64'd0);
    checkOutput("rst_perf_stalls", 64'(perf_stall_cycles), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      applyStimulus(tbl[i], $sformatf("v%0d", i));

    // Abort while a ROW_PTR word is stalled.
    prepTransfer(tbl[0]);
    w0 = perf_words_sent;
    s0 = perf_stall_cycles;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    bus.dma_meta_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk);
      seen = bus.dma_meta_wen && bus.dma_meta_type == 2'd2 && bus.dma_meta_data == tbl[0].exp_hdr1;
    end
    checkOutput("abort_hdr1_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    bus.dma_meta_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_stalled_wen", 64'(bus.dma_meta_wen), 64'd1);
    checkOutput("abort_stalled_data", 64'(bus.dma_meta_data), 64'hA000_0000);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_wen", 64'(bus.dma_meta_wen), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd0);
    drive_en = 1'b0;
    bus.dma_meta_ready = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("abort_no_done", 64'(done_cnt - d0), 64'd0);
    checkOutput("abort_words_seen", 64'(got.size()), 64'd2);
    checkOutput("abort_perf_words", 64'(perf_words_sent - w0), 64'd2);
    checkOutput("abort_perf_stalls", 64'(perf_stall_cycles - s0), 64'd1);
    applyStimulus(tbl[0], "after_abort");

    // Asynchronous reset in the middle of COL_IDX.
    prepTransfer(tbl[0]);
    @(posedge clk); #1;
    start = 1'b1;
    bus.dma_meta_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 40 && !seen; j++) begin
      @(negedge clk);
      seen = bus.dma_meta_wen && bus.dma_meta_type == 2'd1;
    end
    checkOutput("rstmid_colidx_seen", 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("rstmid_wen", 64'(bus.dma_meta_wen), 64'd0);
    checkOutput("rstmid_data", 64'(bus.dma_meta_data), 64'd0);
    checkOutput("rstmid_valid", 64'(bus.dma_meta_valid), 64'd0);
    checkOutput("rstmid_type", 64'(bus.dma_meta_type), 64'd0);
    checkOutput("rstmid_busy", 64'(busy), 64'd0);
    checkOutput("rstmid_done", 64'(done), 64'd0);
    checkOutput("rstmid_perf_words", 64'(perf_words_sent), 64'd0);
    checkOutput("rstmid_perf_stalls", 64'(perf_stall_cycles), 64'd0);
    drive_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstmid_idle_busy", 64'(busy), 64'd0);
    checkOutput("rstmid_idle_wen", 64'(bus.dma_meta_wen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
